// File: rtl/j1_io_uart_pkg.sv
// Shared I/O map, status bit positions and FSM encodings for the J1 UART peripheral.
package j1_io_uart_pkg;

    localparam int WIDTH = 16;

    localparam logic [15:0] A_DATA = 16'h1000;
    localparam logic [15:0] A_STAT = 16'h2000;
    localparam int ADDR_DATA_BIT = 12;
    localparam int ADDR_STAT_BIT = 13;

    localparam int ST_TX_READY  = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic int baud_div(input int clkfreq, input int baud);
        return clkfreq / baud;
    endfunction

endpackage

// File: rtl/j1_uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle done / frame-error pulses.
module j1_uart_rx
    import j1_io_uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_ferr
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic          done_d, ferr_d;
    logic          bit_end;

    // Synchronisers reset high so the idle line never looks like a start edge.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign bit_end = (cnt == '0);

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            S_IDLE: if (rx_prev && !rx_sync) begin
                state_d = S_START;
                cnt_d   = HALF;
            end
            S_START: if (!bit_end) cnt_d = cnt - CW'(1);
            else if (rx_sync) state_d = S_IDLE;
            else begin
                state_d   = S_DATA;
                cnt_d     = FULL;
                bit_idx_d = 3'd0;
            end
            S_DATA: if (!bit_end) cnt_d = cnt - CW'(1);
            else begin
                shift_d   = {rx_sync, shift[7:1]};
                cnt_d     = FULL;
                bit_idx_d = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_d = S_STOP;
            end
            default: if (!bit_end) cnt_d = cnt - CW'(1);
            else begin
                state_d = S_IDLE;
                done_d  = rx_sync;
                ferr_d  = !rx_sync;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            rx_done <= done_d;
            rx_ferr <= ferr_d;
        end
    end

    assign rx_data = shift;

endmodule

// File: rtl/j1_io_uart.sv
// Memory-mapped 8N1 UART on the J1 I/O port: TX holding register + shifter, RX buffer, status flags.
module j1_io_uart
    import j1_io_uart_pkg::*;
#(
    parameter int CLKFREQ = 48000000,
    parameter int BAUD    = 115200
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_wr,
    input  logic             io_rd,
    input  logic [15:0]      mem_addr,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] io_din,
    input  logic             uart_rx,
    output logic             uart_tx
);

    localparam int DIV = baud_div(CLKFREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    logic          sel_data, sel_stat, wr_data, wr_stat, pop;
    logic          hold_full, hold_full_d, tx_ready;
    logic [7:0]    hold_byte;
    logic [1:0]    tx_state, tx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          tx_line_d, tx_bit_end;

    logic [7:0]    rx_data, rx_byte;
    logic          rx_done, rx_ferr;
    logic          rx_valid, overrun, frame_err, rx_store, overrun_set;
    logic          unused_ok;

    assign sel_data = mem_addr[ADDR_DATA_BIT];
    assign sel_stat = mem_addr[ADDR_STAT_BIT];
    assign wr_data  = io_wr & sel_data;
    assign wr_stat  = io_wr & sel_stat;
    assign pop      = io_rd & sel_data;
    assign tx_ready = ~hold_full;
    assign unused_ok = &{1'b0, mem_addr[15:14], mem_addr[11:0], dout[WIDTH-1:8]};

    assign tx_bit_end = (tx_cnt == '0);

    always_comb begin
        tx_state_d  = tx_state;
        tx_cnt_d    = tx_cnt;
        tx_bit_d    = tx_bit;
        tx_shift_d  = tx_shift;
        hold_full_d = hold_full;
        case (tx_state)
            S_IDLE: ;
            S_START: if (!tx_bit_end) tx_cnt_d = tx_cnt - CW'(1);
            else begin
                tx_state_d = S_DATA;
                tx_cnt_d   = FULL;
                tx_bit_d   = 3'd0;
            end
            S_DATA: if (!tx_bit_end) tx_cnt_d = tx_cnt - CW'(1);
            else begin
                tx_cnt_d   = FULL;
                tx_shift_d = {1'b0, tx_shift[7:1]};
                tx_bit_d   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_d = S_STOP;
            end
            default: if (!tx_bit_end) tx_cnt_d = tx_cnt - CW'(1);
            else tx_state_d = S_IDLE;
        endcase
        // Holding register is drained whenever the shifter would otherwise go idle,
        // so a byte queued during STOP starts its frame with no idle gap.
        if (hold_full && (tx_state == S_IDLE || (tx_state == S_STOP && tx_bit_end))) begin
            tx_state_d  = S_START;
            tx_cnt_d    = FULL;
            tx_shift_d  = hold_byte;
            hold_full_d = 1'b0;
        end
        if (wr_data && !hold_full) hold_full_d = 1'b1;
        case (tx_state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= 3'd0;
            tx_shift  <= 8'h00;
            hold_full <= 1'b0;
            hold_byte <= 8'h00;
            uart_tx   <= 1'b1;
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_bit    <= tx_bit_d;
            tx_shift  <= tx_shift_d;
            hold_full <= hold_full_d;
            uart_tx   <= tx_line_d;
            if (wr_data && !hold_full) hold_byte <= dout[7:0];
        end
    end

    j1_uart_rx #(.DIV(DIV)) u_rx (
        .clk     (clk),
        .resetq  (resetq),
        .uart_rx (uart_rx),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .rx_ferr (rx_ferr)
    );

    // A same-edge pop frees the buffer, so the new byte loads without flagging overrun.
    assign rx_store    = rx_done & (~rx_valid | pop);
    assign overrun_set = rx_done & rx_valid & ~pop;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_store) rx_byte <= rx_data;
            rx_valid  <= rx_store | (rx_valid & ~pop);
            overrun   <= overrun_set | (overrun & ~(wr_stat & dout[ST_OVERRUN]));
            frame_err <= rx_ferr | (frame_err & ~(wr_stat & dout[ST_FRAME_ERR]));
        end
    end

    always_comb begin
        io_din = '0;
        if (sel_data) begin
            io_din[7:0] = rx_byte;
        end else if (sel_stat) begin
            io_din[ST_FRAME_ERR] = frame_err;
            io_din[ST_OVERRUN]   = overrun;
            io_din[ST_RX_VALID]  = rx_valid;
            io_din[ST_TX_READY]  = tx_ready;
        end
    end

endmodule
